// File: rtl/des_f_pipe.sv
// DES round function f(R,K) as a two-stage valid/ready pipeline.
// Stage 1 holds E(R)^K, stage 2 holds P(S1..S8) and drives the outputs directly.
module des_f_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_r,
  input  logic [47:0] in_k,
  input  logic [3:0]  in_tag,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_f,
  output logic [3:0]  out_tag,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int unsigned RW   = 32;
  localparam int unsigned KW   = 48;
  localparam int unsigned TW   = 4;
  localparam int unsigned NBOX = 8;

  logic [KW-1:0] x1;
  logic [TW-1:0] t1;
  logic          v1;
  logic          v2;
  logic          ld2;
  logic          acc;
  logic [KW-1:0] e_r;
  logic [RW-1:0] s_out;
  logic [RW-1:0] p_out;

  // Stage 2 loads whenever it is empty or its content leaves this cycle.
  assign ld2       = v1 & (~v2 | out_ready);
  assign in_ready  = rst & (~v1 | ld2);
  assign acc       = in_valid & in_ready;
  assign out_valid = v2;

  // Expansion E: each 6-bit group overlaps its neighbours by one bit, wrapping at the ends.
  assign e_r = {in_r[0],     in_r[31:27], in_r[28:23], in_r[24:19],
                in_r[20:15], in_r[16:11], in_r[12:7],  in_r[8:3],
                in_r[4:0],   in_r[31]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      t1 <= '0;
    end else if (acc) begin
      v1 <= 1'b1;
      x1 <= e_r ^ in_k;
      t1 <= in_tag;
    end else if (ld2) begin
      v1 <= 1'b0;
    end
  end

  for (genvar j = 0; j < NBOX; j++) begin : g_sbox
    des_f_sbox #(.BOX(j + 1)) u_sbox (
      .in  (x1[KW-1-6*j -: 6]),
      .out (s_out[RW-1-4*j -: 4])
    );
  end

  // Permutation P.
  assign p_out = {s_out[16], s_out[25], s_out[12], s_out[11],
                  s_out[3],  s_out[20], s_out[4],  s_out[15],
                  s_out[31], s_out[17], s_out[9],  s_out[6],
                  s_out[27], s_out[14], s_out[1],  s_out[22],
                  s_out[30], s_out[24], s_out[8],  s_out[18],
                  s_out[0],  s_out[5],  s_out[29], s_out[23],
                  s_out[13], s_out[19], s_out[2],  s_out[26],
                  s_out[10], s_out[21], s_out[28], s_out[7]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      v2      <= 1'b0;
      out_f   <= '0;
      out_tag <= '0;
    end else if (ld2) begin
      v2      <= 1'b1;
      out_f   <= p_out;
      out_tag <= t1;
    end else if (out_ready) begin
      v2      <= 1'b0;
    end
  end
endmodule

// One DES S-box; table entries listed row-major, entry 0 in the top nibble.
module des_f_sbox #(
  parameter int unsigned BOX = 1
) (
  input  logic [5:0] in,
  output logic [3:0] out
);
  localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  localparam logic [255:0] TAB = (BOX == 1) ? S1 : (BOX == 2) ? S2 :
                                 (BOX == 3) ? S3 : (BOX == 4) ? S4 :
                                 (BOX == 5) ? S5 : (BOX == 6) ? S6 :
                                 (BOX == 7) ? S7 : S8;

  logic [5:0] idx;
  logic [7:0] lsb;

  // Outer bits select the row, inner four bits the column.
  assign idx = {in[5], in[0], in[4:1]};
  assign lsb = 8'd252 - {idx, 2'b00};
  assign out = TAB[lsb +: 4];
endmodule

// File: tb/tb_des_f_pipe.sv
// Directed and random bench for des_f_pipe against a table-driven f(R,K) model.
module tb_des_f_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_r;
  logic [47:0] in_k;
  logic [3:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_f;
  logic [3:0]  out_tag;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_f_pipe dut (
    .clk(clk), .rst(rst), .in_r(in_r), .in_k(in_k), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready), .out_f(out_f), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                     12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int sbox [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  // Reference f(R,K) built from the published tables, DES bit n at vector bit (width - n).
  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  c;
    int          row;
    int          col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-e_tab[i]];
    x = e ^ k;
    for (int j = 0; j < 8; j++) begin
      c   = x[47-6*j -: 6];
      row = 2 * int'(c[5]) + int'(c[0]);
      col = int'(c[4:1]);
      s[31-4*j -: 4] = 4'(sbox[j][row*16+col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-p_tab[i]];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [47:0] k, input logic [3:0] t);
    in_valid = v;
    in_r     = r;
    in_k     = k;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 48'h0, 4'h0);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low got %b exp 0", in_ready); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_f !== 32'h0) begin errors++; $display("FAIL rst_out_f got %h exp 0", out_f); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag got %h exp 0", out_tag); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_reference();
    out_ready = 1'b1;
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'h5);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ref_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (dut.x1 !== 48'h6117BA866527) begin errors++; $display("FAIL ref_x1 got %h exp 6117ba866527", dut.x1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ref_early_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ref_valid got %b exp 1", out_valid); end
    checks++; if (out_f !== 32'h234AA9BB) begin errors++; $display("FAIL ref_out_f got %h exp 234aa9bb", out_f); end
    checks++; if (out_tag !== 4'h5) begin errors++; $display("FAIL ref_out_tag got %h exp 5", out_tag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ref_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] ef [8];
    logic [31:0] r;
    logic [47:0] k;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        r = $urandom();
        k = {16'($urandom()), $urandom()};
        ef[c] = f_model(r, k);
        drive(1'b1, r, k, 4'(c));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=%0d got %b exp 1", c, in_ready); end
      end
      tick();
      if (c >= 1 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'(c - 1) || out_f !== ef[c-1]) begin
          errors++;
          $display("FAIL stream_out c=%0d got v=%b tag=%h f=%h exp v=1 tag=%h f=%h",
                   c, out_valid, out_tag, out_f, 4'(c - 1), ef[c-1]);
        end
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] br [3];
    logic [47:0] bk [3];
    logic [31:0] bf [3];
    logic [3:0]  bt [3];
    int          idx = 0;
    int          got = 0;
    logic        acc;
    for (int i = 0; i < 3; i++) begin
      br[i] = $urandom();
      bk[i] = {16'($urandom()), $urandom()};
      bf[i] = f_model(br[i], bk[i]);
      bt[i] = 4'(8 + i);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, br[idx], bk[idx], bt[idx]);
      #1;
      acc = in_ready;
      if (c >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low c=%0d got %b exp 0", c, in_ready); end
        checks++; if (out_f !== bf[0] || out_tag !== bt[0]) begin errors++; $display("FAIL bp_hold c=%0d got f=%h tag=%h exp f=%h tag=%h", c, out_f, out_tag, bf[0], bt[0]); end
      end
      tick();
      if (acc) idx++;
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
    out_ready = 1'b1;
    for (int n = 0; n < 12 && got < 3; n++) begin
      if (idx < 3) drive(1'b1, br[idx], bk[idx], bt[idx]);
      else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (out_f !== bf[got] || out_tag !== bt[got]) begin
          errors++;
          $display("FAIL bp_drain n=%0d got f=%h tag=%h exp f=%h tag=%h", got, out_f, out_tag, bf[got], bt[got]);
        end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++; if (got != 3 || idx != 3) begin errors++; $display("FAIL bp_count got results=%0d accepted=%0d exp 3 and 3", got, idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] r1;
    logic [47:0] k1;
    logic [31:0] f1;
    r1 = 32'h12345678;
    k1 = 48'hA5A5_0F0F_3C3C;
    f1 = f_model(r1, k1);
    out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 48'h0123_4567_89AB, 4'hB);
    tick();
    drive(1'b1, r1, k1, 4'hC);
    tick();
    in_valid = 1'b0;
    checks++; if (dut.v1 !== 1'b1 || out_valid !== 1'b1 || out_tag !== 4'hB) begin errors++; $display("FAIL sim_full got v1=%b v=%b tag=%h exp v1=1 v=1 tag=b", dut.v1, out_valid, out_tag); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sim_refill_valid got %b exp 1", out_valid); end
    checks++; if (out_tag !== 4'hC || out_f !== f1) begin errors++; $display("FAIL sim_refill_data got tag=%h f=%h exp tag=c f=%h", out_tag, out_f, f1); end
    checks++; if (dut.v1 !== 1'b0) begin errors++; $display("FAIL sim_stage1_empty got %b exp 0", dut.v1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'hC) begin errors++; $display("FAIL sim_hold got v=%b tag=%h exp v=1 tag=c", out_valid, out_tag); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sim_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 32'h0F0F0F0F, 48'hFFFF_0000_FFFF, 4'hD);
    tick();
    drive(1'b1, 32'h87654321, 48'h1111_2222_3333, 4'hE);
    tick();
    in_valid = 1'b0;
    checks++; if (dut.v1 !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rstm_full got v1=%b v=%b exp 1 1", dut.v1, out_valid); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid got %b exp 0", out_valid); end
    checks++; if (out_f !== 32'h0) begin errors++; $display("FAIL rstm_out_f got %h exp 0", out_f); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rstm_out_tag got %h exp 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_ghost c=%0d got v=%b tag=%h exp v=0", c, out_valid, out_tag); end
    end
  endtask

  task automatic test_random();
    logic [31:0] qf[$];
    logic [3:0]  qt[$];
    logic [31:0] r;
    logic [47:0] k;
    logic [3:0]  t;
    logic [31:0] ef;
    logic [3:0]  et;
    int          sent = 0;
    int          cyc = 0;
    while ((sent < 10000 || qf.size() > 0) && cyc < 60000) begin
      r = $urandom();
      k = {16'($urandom()), $urandom()};
      t = 4'($urandom());
      drive((sent < 10000) && ($urandom_range(3) != 0), r, k, t);
      out_ready = (sent >= 10000) || ($urandom_range(1) == 1);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (qf.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got tag=%h f=%h exp no result", out_tag, out_f);
        end else begin
          ef = qf.pop_front();
          et = qt.pop_front();
          if (out_f !== ef || out_tag !== et) begin
            errors++;
            $display("FAIL rand_out cyc=%0d got f=%h tag=%h exp f=%h tag=%h", cyc, out_f, out_tag, ef, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        qf.push_back(f_model(r, k));
        qt.push_back(t);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (sent != 10000 || qf.size() != 0) begin errors++; $display("FAIL rand_complete got sent=%0d pending=%0d exp 10000 0", sent, qf.size()); end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
